// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-port mode encodings and a sizing helper.
package fifo_pkg;

    localparam int FIFO_FWFT = 0;  // first-word-fall-through read port
    localparam int FIFO_REG  = 1;  // registered read port, one-cycle pop latency

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Pointer register counting 0..DEPTH-1 with an explicit wrap, so any depth works.
module fifo_wrap_ptr #(
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_d, ptr_q;

    // Clear wins over increment; the last slot wraps straight back to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (clr)
            ptr_d = '0;
        else if (inc)
            ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end

    // Pointer state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, occupancy count, runtime thresholds,
// FWFT or registered read port, synchronous flush and sticky error flags.
module sync_fifo_prog import fifo_pkg::*; #(
    parameter int DATA_SIZE = 32,
    parameter int FIFO_SIZE = 8,
    parameter int OUT_MODE  = FIFO_FWFT,
    localparam int CNT_W     = cnt_width(FIFO_SIZE),
    localparam int ADD_WIDTH = $clog2(FIFO_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [CNT_W-1:0]     af_thresh,
    input  logic [CNT_W-1:0]     ae_thresh,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    logic [DATA_SIZE-1:0] mem_q [FIFO_SIZE];
    logic [ADD_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count_d, count_q;
    logic                 ovf_d, ovf_q, udf_d, udf_q;
    logic                 wr_acc, pop_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(FIFO_SIZE));

    // Accept decisions; a pop on a full FIFO frees the slot the push needs.
    assign pop_acc = pop & ~empty & ~flush;
    assign wr_acc  = push & ~flush & (~full | pop_acc);

    fifo_wrap_ptr #(.DEPTH(FIFO_SIZE)) u_wr_ptr (
        .clk (clk), .rst (rst), .clr (flush), .inc (wr_acc), .ptr (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(FIFO_SIZE)) u_rd_ptr (
        .clk (clk), .rst (rst), .clr (flush), .inc (pop_acc), .ptr (rd_ptr)
    );

    // Storage is written only on an accepted push; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr] <= data_in;
    end

    // Occupancy and sticky error next-state; flush clears everything.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case ({wr_acc, pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push & full & ~pop_acc) ovf_d = 1'b1;
            if (pop & empty)            udf_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign almost_empty = (count_q <= ae_thresh);
    assign almost_full  = (count_q >= af_thresh);

    generate
        if (OUT_MODE == FIFO_REG) begin : g_reg
            logic [DATA_SIZE-1:0] dout_d, dout_q;
            logic                 dv_d, dv_q;

            // Capture the head on each accepted pop; valid lasts one cycle.
            always_comb begin
                dout_d = dout_q;
                dv_d   = 1'b0;
                if (pop_acc) begin
                    dout_d = mem_q[rd_ptr];
                    dv_d   = 1'b1;
                end
            end

            // Registered read port.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dv_q   <= dv_d;
                end
            end

            assign data_out   = dout_q;
            assign data_valid = dv_q;
        end else begin : g_fwft
            // Head is presented directly; masked to zero while empty so reset shows 0.
            assign data_out   = empty ? '0 : mem_q[rd_ptr];
            assign data_valid = ~empty;
        end
    endgenerate

endmodule
